// File: rtl/cdbus_sim_pkg.sv
// rtl/cdbus_sim_pkg.sv - shared types, idle level and popcount for the CDBUS bus model
package cdbus_sim_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } bus_state_t;

  localparam logic BUS_IDLE_LVL = 1'b1;

  function automatic logic [4:0] popcount(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + 5'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/cdbus_delay_line.sv
// rtl/cdbus_delay_line.sv - async-reset shift register, pass-through when DEPTH is 0
module cdbus_delay_line #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset_n;
    assign q = d;
  end else begin : g_shift
    logic [DEPTH-1:0] sr;

    // Reset forces every stage to the idle level so nothing stale leaks out after release.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sr <= {DEPTH{RST_VAL}};
      end else begin
        sr[0] <= d;
        for (int i = 1; i < DEPTH; i++) begin
          sr[i] <= sr[i-1];
        end
      end
    end

    assign q = sr[DEPTH-1];
  end

endmodule

// File: rtl/cdbus_bus_model.sv
// rtl/cdbus_bus_model.sv - shared dominant-low CDBUS wire with delay, echo, conflict count and busy tracking
module cdbus_bus_model
  import cdbus_sim_pkg::*;
#(
  parameter int N_NODES    = 2,
  parameter int DELAY      = 2,
  parameter int LOCAL_ECHO = 1,
  parameter int IDLE_CYC   = 4,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [N_NODES-1:0]           tx,
  input  logic [N_NODES-1:0]           tx_en,
  input  logic                         clr_cnt,
  output logic [N_NODES-1:0]           rx,
  output logic                         bus_o,
  output logic [$clog2(N_NODES+1)-1:0] drv_cnt,
  output logic                         conflict,
  output logic [CNT_W-1:0]             conflict_cnt,
  output logic                         busy
);

  localparam int DRV_W = $clog2(N_NODES + 1);

  if (N_NODES < 2 || N_NODES > 16) begin : g_bad_nodes
    $error("cdbus_bus_model: N_NODES must be 2..16");
  end
  if (DELAY < 0 || DELAY > 15) begin : g_bad_delay
    $error("cdbus_bus_model: DELAY must be 0..15");
  end
  if (LOCAL_ECHO < 0 || LOCAL_ECHO > 1) begin : g_bad_echo
    $error("cdbus_bus_model: LOCAL_ECHO must be 0 or 1");
  end
  if (IDLE_CYC < 1 || IDLE_CYC > 255) begin : g_bad_idle
    $error("cdbus_bus_model: IDLE_CYC must be 1..255");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("cdbus_bus_model: CNT_W must be at least 1");
  end

  logic       res;
  logic       any0;
  logic       any1;
  logic       dis;
  logic       wire_d;
  logic       any_en;
  bus_state_t state;
  bus_state_t state_nx;
  logic [7:0] qcnt;
  logic [7:0] qcnt_nx;

  // Wired-AND of enabled drivers; an undriven bus floats to the pull-up level.
  always_comb begin
    res  = BUS_IDLE_LVL;
    any0 = 1'b0;
    any1 = 1'b0;
    for (int i = 0; i < N_NODES; i++) begin
      if (tx_en[i]) begin
        if (tx[i]) begin
          any1 = 1'b1;
        end else begin
          any0 = 1'b1;
          res  = 1'b0;
        end
      end
    end
  end

  assign dis    = any0 & any1;
  assign any_en = |tx_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_o        <= BUS_IDLE_LVL;
      drv_cnt      <= '0;
      conflict     <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      bus_o    <= res;
      drv_cnt  <= DRV_W'(popcount(16'(tx_en)));
      conflict <= dis;
      if (clr_cnt) begin
        conflict_cnt <= '0;
      end else if (dis && !(&conflict_cnt)) begin
        conflict_cnt <= conflict_cnt + 1'b1;
      end
    end
  end

  cdbus_delay_line #(
    .DEPTH  (DELAY),
    .RST_VAL(BUS_IDLE_LVL)
  ) u_delay (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (bus_o),
    .q      (wire_d)
  );

  always_comb begin
    rx = '0;
    for (int i = 0; i < N_NODES; i++) begin
      rx[i] = (LOCAL_ECHO != 0 && tx_en[i]) ? tx[i] : wire_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      qcnt  <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      qcnt  <= qcnt_nx;
      busy  <= (state_nx != IDLE);
    end
  end

  // DRAIN waits for IDLE_CYC quiet, released-high cycles before declaring the bus idle.
  always_comb begin
    state_nx = state;
    qcnt_nx  = qcnt;
    case (state)
      IDLE: begin
        if (any_en) begin
          state_nx = ACTIVE;
        end
      end
      ACTIVE: begin
        if (!any_en && bus_o) begin
          state_nx = DRAIN;
          qcnt_nx  = 8'd1;
        end
      end
      DRAIN: begin
        if (any_en || !bus_o) begin
          state_nx = ACTIVE;
          qcnt_nx  = '0;
        end else if (qcnt == 8'(IDLE_CYC)) begin
          state_nx = IDLE;
          qcnt_nx  = '0;
        end else begin
          qcnt_nx = qcnt + 8'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        qcnt_nx  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_cdbus_bus_model.sv
// tb/tb_cdbus_bus_model.sv - scoreboard bench driving two differently configured bus models
module tb_cdbus_bus_model;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] tx = '1;
  logic [N-1:0] tx_en = '0;
  logic         clr_cnt = 1'b0;

  logic [N-1:0] rx_a, rx_b;
  logic         bus_a, bus_b;
  logic [1:0]   drv_a, drv_b;
  logic         conf_a, conf_b;
  logic [2:0]   cnt_a;
  logic [1:0]   cnt_b;
  logic         busy_a, busy_b;

  always #5 clk = ~clk;

  cdbus_bus_model #(
    .N_NODES(3), .DELAY(2), .LOCAL_ECHO(1), .IDLE_CYC(4), .CNT_W(3)
  ) u_a (
    .clk(clk), .reset_n(reset_n), .tx(tx), .tx_en(tx_en), .clr_cnt(clr_cnt),
    .rx(rx_a), .bus_o(bus_a), .drv_cnt(drv_a), .conflict(conf_a),
    .conflict_cnt(cnt_a), .busy(busy_a)
  );

  cdbus_bus_model #(
    .N_NODES(3), .DELAY(0), .LOCAL_ECHO(0), .IDLE_CYC(2), .CNT_W(2)
  ) u_b (
    .clk(clk), .reset_n(reset_n), .tx(tx), .tx_en(tx_en), .clr_cnt(clr_cnt),
    .rx(rx_b), .bus_o(bus_b), .drv_cnt(drv_b), .conflict(conf_b),
    .conflict_cnt(cnt_b), .busy(busy_b)
  );

  typedef struct packed {
    logic [N-1:0] rx;
    logic         bus;
    logic [1:0]   drv;
    logic         conf;
    logic [3:0]   cnt;
    logic         busy;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  // Reference state: the resolved wire level after each edge, indexed by edge number.
  bit bus_log[$];
  int last_rst = 0;
  int m_cnt[2];
  bit m_busy[2];
  int m_run[2];

  function automatic int p_delay(input int d);
    return (d == 0) ? 2 : 0;
  endfunction
  function automatic bit p_echo(input int d);
    return (d == 0);
  endfunction
  function automatic int p_idle(input int d);
    return (d == 0) ? 4 : 2;
  endfunction
  function automatic int p_cmax(input int d);
    return (d == 0) ? 7 : 3;
  endfunction

  function automatic bit wire_seen(input int dly);
    int k;
    k = bus_log.size() - 1;
    if (k - dly <= last_rst) return 1'b1;
    return bus_log[k - dly];
  endfunction

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic drive(input logic [N-1:0] t, input logic [N-1:0] e, input logic c, input logic r);
    int   zeros, ones;
    bit   old_bus, dis;
    exp_t x;
    @(negedge clk);
    tx = t;
    tx_en = e;
    clr_cnt = c;
    reset_n = r;
    zeros = 0;
    ones = 0;
    for (int i = 0; i < N; i++) begin
      if (e[i]) begin
        if (t[i]) ones++;
        else zeros++;
      end
    end
    dis = (zeros > 0) && (ones > 0);
    old_bus = bus_log[bus_log.size() - 1];
    if (!r) begin
      bus_log.push_back(1'b1);
      last_rst = bus_log.size() - 1;
    end else begin
      bus_log.push_back(zeros == 0);
    end
    for (int d = 0; d < 2; d++) begin
      if (!r) begin
        m_cnt[d] = 0;
        m_busy[d] = 1'b0;
        m_run[d] = 0;
        x.drv = '0;
        x.conf = 1'b0;
      end else begin
        if (!m_busy[d]) begin
          if (e != 0) begin
            m_busy[d] = 1'b1;
            m_run[d] = 0;
          end
        end else if (e == 0 && old_bus) begin
          m_run[d]++;
          if (m_run[d] > p_idle(d)) begin
            m_busy[d] = 1'b0;
            m_run[d] = 0;
          end
        end else begin
          m_run[d] = 0;
        end
        if (c) m_cnt[d] = 0;
        else if (dis && m_cnt[d] < p_cmax(d)) m_cnt[d]++;
        x.drv = 2'(zeros + ones);
        x.conf = dis;
      end
      x.bus = bus_log[bus_log.size() - 1];
      x.cnt = 4'(m_cnt[d]);
      x.busy = m_busy[d];
      for (int i = 0; i < N; i++) begin
        x.rx[i] = (p_echo(d) && e[i]) ? t[i] : wire_seen(p_delay(d));
      end
      if (d == 0) qa.push_back(x);
      else qb.push_back(x);
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        x = qa.pop_front();
        check("a_rx", int'(rx_a), int'(x.rx));
        check("a_bus_o", int'(bus_a), int'(x.bus));
        check("a_drv_cnt", int'(drv_a), int'(x.drv));
        check("a_conflict", int'(conf_a), int'(x.conf));
        check("a_conflict_cnt", int'(cnt_a), int'(x.cnt));
        check("a_busy", int'(busy_a), int'(x.busy));
      end
      if (qb.size() > 0) begin
        x = qb.pop_front();
        check("b_rx", int'(rx_b), int'(x.rx));
        check("b_bus_o", int'(bus_b), int'(x.bus));
        check("b_drv_cnt", int'(drv_b), int'(x.drv));
        check("b_conflict", int'(conf_b), int'(x.conf));
        check("b_conflict_cnt", int'(cnt_b), int'(x.cnt));
        check("b_busy", int'(busy_b), int'(x.busy));
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    int len, mode;
    logic [N-1:0] e, t;
    bus_log.push_back(1'b1);
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 0;
      m_busy[d] = 1'b0;
      m_run[d] = 0;
    end

    repeat (2) drive(3'b111, 3'b000, 1'b0, 1'b0);
    repeat (3) drive(3'b111, 3'b000, 1'b0, 1'b1);
    // node0 pulls low for five cycles, then the bus drains
    repeat (5) drive(3'b110, 3'b001, 1'b0, 1'b1);
    repeat (8) drive(3'b111, 3'b000, 1'b0, 1'b1);
    // echo-off pattern 1,0,1 from node0
    drive(3'b111, 3'b001, 1'b0, 1'b1);
    drive(3'b110, 3'b001, 1'b0, 1'b1);
    drive(3'b111, 3'b001, 1'b0, 1'b1);
    repeat (3) drive(3'b111, 3'b000, 1'b0, 1'b1);
    // node0 low against node1 high: three conflict cycles
    repeat (3) drive(3'b010, 3'b011, 1'b0, 1'b1);
    repeat (2) drive(3'b111, 3'b000, 1'b0, 1'b1);
    repeat (5) drive(3'b010, 3'b011, 1'b0, 1'b1);
    drive(3'b010, 3'b011, 1'b1, 1'b1);
    repeat (8) drive(3'b111, 3'b000, 1'b0, 1'b1);
    // re-enable a driver while draining
    drive(3'b110, 3'b001, 1'b0, 1'b1);
    repeat (3) drive(3'b111, 3'b000, 1'b0, 1'b1);
    drive(3'b111, 3'b001, 1'b0, 1'b1);
    repeat (8) drive(3'b111, 3'b000, 1'b0, 1'b1);
    // reset in the middle of traffic
    repeat (2) drive(3'b100, 3'b011, 1'b0, 1'b1);
    repeat (2) drive(3'b100, 3'b011, 1'b0, 1'b0);
    repeat (4) drive(3'b111, 3'b000, 1'b0, 1'b1);
    // enables toggling every cycle
    repeat (10) begin
      drive(3'b110, 3'b001, 1'b0, 1'b1);
      drive(3'b111, 3'b000, 1'b0, 1'b1);
    end

    repeat (80) begin
      len = $urandom_range(1, 8);
      mode = $urandom_range(0, 3);
      repeat (len) begin
        t = N'($urandom);
        e = (mode == 0) ? '0 : N'($urandom);
        drive(t, e, ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) != 0));
      end
    end

    done = 1'b1;
    repeat (3) @(negedge clk);
    check("queue_a_empty", qa.size(), 0);
    check("queue_b_empty", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
